// File: rtl/key_pkg.sv
// Shared types and default constants for the key input conditioner.
// Debounce state encoding plus a small elaboration-time helper.
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int DEF_NUM_KEYS        = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_PERIOD   = 5_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: 2-flop synchronizer, debounce FSM, auto-repeat counter.
// All outputs are registered and derived from the next state.
module key_debounce_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RPT_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_PERIOD = RW'(REPEAT_PERIOD);
    localparam bit            RPT_EN     = (REPEAT_DELAY > 0);

    logic s1, s2;

    key_state_t    state, state_nx;
    logic [DW-1:0] db_cnt, db_cnt_nx;
    logic [RW-1:0] rpt_cnt, rpt_cnt_nx;
    logic [RW-1:0] rpt_inc, rpt_target;
    logic          rpt_first, rpt_first_nx;
    logic          pressed_nx, press_nx, release_nx, repeat_nx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= RELEASED;
            db_cnt        <= '0;
            rpt_cnt       <= '0;
            rpt_first     <= 1'b1;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_nx;
            db_cnt        <= db_cnt_nx;
            rpt_cnt       <= rpt_cnt_nx;
            rpt_first     <= rpt_first_nx;
            pressed       <= pressed_nx;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
            repeat_pulse  <= repeat_nx;
        end
    end

    // The repeat counter restarts after each pulse, so it only ever
    // has to reach the larger of the two intervals.
    always_comb begin
        state_nx     = state;
        db_cnt_nx    = db_cnt;
        rpt_cnt_nx   = rpt_cnt;
        rpt_first_nx = rpt_first;
        press_nx     = 1'b0;
        release_nx   = 1'b0;
        repeat_nx    = 1'b0;
        rpt_inc      = rpt_cnt + RW'(1);
        rpt_target   = rpt_first ? RPT_DELAY : RPT_PERIOD;

        unique case (state)
            RELEASED: begin
                rpt_cnt_nx   = '0;
                rpt_first_nx = 1'b1;
                if (!s2) begin
                    state_nx  = PRESS_WAIT;
                    db_cnt_nx = '0;
                end
            end
            PRESS_WAIT: begin
                if (s2) begin
                    state_nx = RELEASED;
                end else if (db_cnt == DB_LAST) begin
                    state_nx     = PRESSED;
                    press_nx     = 1'b1;
                    rpt_cnt_nx   = '0;
                    rpt_first_nx = 1'b1;
                end else begin
                    db_cnt_nx = db_cnt + DW'(1);
                end
            end
            PRESSED: begin
                if (s2) begin
                    state_nx  = RELEASE_WAIT;
                    db_cnt_nx = '0;
                end else if (RPT_EN) begin
                    if (rpt_inc == rpt_target) begin
                        repeat_nx    = 1'b1;
                        rpt_cnt_nx   = '0;
                        rpt_first_nx = 1'b0;
                    end else begin
                        rpt_cnt_nx = rpt_inc;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (!s2) begin
                    state_nx = PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_nx   = RELEASED;
                    release_nx = 1'b1;
                end else begin
                    db_cnt_nx = db_cnt + DW'(1);
                end
            end
            default: state_nx = RELEASED;
        endcase

        pressed_nx = (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);
    end

endmodule

// File: rtl/key_debouncer.sv
// Multi-key conditioner: one independent debounce channel per key line.
// Channel outputs are simply gathered into per-key vectors.
module key_debouncer
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = DEF_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clock         (clock),
            .reset         (reset),
            .key_n         (key_n[k]),
            .pressed       (pressed[k]),
            .press_pulse   (press_pulse[k]),
            .release_pulse (release_pulse[k]),
            .repeat_pulse  (repeat_pulse[k])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed scenarios plus random
// key activity against a run-length reference model.
module tb_key_debouncer;

    localparam int NK = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] pressed, press_pulse, release_pulse, repeat_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    key_debouncer #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .key_n         (key_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    // Reference: a level flips once DB+1 consecutive synchronized samples
    // disagree with it; held time counts only undisturbed pressed samples.
    logic          m_s1 [NK];
    logic          m_s2 [NK];
    logic          m_lvl[NK];
    int            m_run [NK];
    int            m_hold[NK];
    logic [NK-1:0] e_pressed = '0;
    logic [NK-1:0] e_press   = '0;
    logic [NK-1:0] e_release = '0;
    logic [NK-1:0] e_repeat  = '0;

    always @(posedge clock or posedge reset) begin : ref_model
        logic l, pp, rl, rp;
        int   r, h;
        if (reset) begin
            for (int k = 0; k < NK; k++) begin
                m_s1[k]   <= 1'b1;
                m_s2[k]   <= 1'b1;
                m_lvl[k]  <= 1'b0;
                m_run[k]  <= 0;
                m_hold[k] <= 0;
            end
            e_pressed <= '0;
            e_press   <= '0;
            e_release <= '0;
            e_repeat  <= '0;
        end else begin
            for (int k = 0; k < NK; k++) begin
                l  = m_lvl[k];
                r  = m_run[k];
                h  = m_hold[k];
                pp = 1'b0;
                rl = 1'b0;
                rp = 1'b0;
                if (m_s2[k] == !l) begin
                    if (l && r == 0) begin
                        h = h + 1;
                        if (RD > 0 && h >= RD && (h - RD) % RP == 0)
                            rp = 1'b1;
                    end
                    r = 0;
                end else begin
                    r = r + 1;
                    if (r == DB + 1) begin
                        l = !l;
                        r = 0;
                        h = 0;
                        if (l) pp = 1'b1;
                        else   rl = 1'b1;
                    end
                end
                m_lvl[k]     <= l;
                m_run[k]     <= r;
                m_hold[k]    <= h;
                m_s2[k]      <= m_s1[k];
                m_s1[k]      <= key_n[k];
                e_pressed[k] <= l;
                e_press[k]   <= pp;
                e_release[k] <= rl;
                e_repeat[k]  <= rp;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        key_n = '1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            n_checks++;
            if ({pressed, press_pulse, release_pulse, repeat_pulse} !==
                {e_pressed, e_press, e_release, e_repeat}) begin
                n_fail++;
                $display("FAIL settle e%0d: got %b expected %b", e,
                    {pressed, press_pulse, release_pulse, repeat_pulse},
                    {e_pressed, e_press, e_release, e_repeat});
            end
        end
    endtask

    task automatic test_reset();
        key_n = '1;
        #1 reset = 1'b1;
        #2;
        n_checks++;
        if ({pressed, press_pulse, release_pulse, repeat_pulse} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0",
                {pressed, press_pulse, release_pulse, repeat_pulse});
        end
        tick();
        tick();
        @(negedge clock) reset = 1'b0;
        settle();
    endtask

    task automatic test_clean_press();
        settle();
        key_n[0] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks++;
            if ({pressed, press_pulse, release_pulse, repeat_pulse} !==
                {e_pressed, e_press, e_release, e_repeat}) begin
                n_fail++;
                $display("FAIL clean_model e%0d: got %b expected %b", e,
                    {pressed, press_pulse, release_pulse, repeat_pulse},
                    {e_pressed, e_press, e_release, e_repeat});
            end
            n_checks++;
            if (press_pulse !== ((e == 7) ? 4'b0001 : 4'b0000) ||
                pressed !== ((e >= 7) ? 4'b0001 : 4'b0000)) begin
                n_fail++;
                $display("FAIL clean_press e%0d: got p=%b pp=%b", e,
                    pressed, press_pulse);
            end
        end
    endtask

    task automatic test_bounce();
        settle();
        for (int e = 1; e <= 14; e++) begin
            key_n[0] = (e == 3);
            tick();
            n_checks++;
            if ({pressed, press_pulse, release_pulse, repeat_pulse} !==
                {e_pressed, e_press, e_release, e_repeat}) begin
                n_fail++;
                $display("FAIL bounce_model e%0d: got %b expected %b", e,
                    {pressed, press_pulse, release_pulse, repeat_pulse},
                    {e_pressed, e_press, e_release, e_repeat});
            end
            n_checks++;
            if (press_pulse[0] !== (e == 10)) begin
                n_fail++;
                $display("FAIL bounce_pulse e%0d: got %b expected %b", e,
                    press_pulse[0], (e == 10));
            end
        end
    endtask

    task automatic test_release();
        for (int e = 1; e <= 10; e++) begin
            key_n[0] = (e <= 2);
            tick();
            n_checks++;
            if (release_pulse[0] !== 1'b0 || pressed[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL release_glitch e%0d: got p=%b rl=%b", e,
                    pressed[0], release_pulse[0]);
            end
        end
        key_n[0] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks++;
            if ({pressed, press_pulse, release_pulse, repeat_pulse} !==
                {e_pressed, e_press, e_release, e_repeat}) begin
                n_fail++;
                $display("FAIL release_model e%0d: got %b expected %b", e,
                    {pressed, press_pulse, release_pulse, repeat_pulse},
                    {e_pressed, e_press, e_release, e_repeat});
            end
            n_checks++;
            if (release_pulse[0] !== (e == 7) || pressed[0] !== (e < 7)) begin
                n_fail++;
                $display("FAIL release e%0d: got p=%b rl=%b", e,
                    pressed[0], release_pulse[0]);
            end
        end
    endtask

    task automatic test_auto_repeat();
        int p;
        logic want;
        settle();
        p = 0;
        key_n[1] = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (press_pulse[1] === 1'b1 && p == 0) p = e;
            n_checks++;
            if ({pressed, press_pulse, release_pulse, repeat_pulse} !==
                {e_pressed, e_press, e_release, e_repeat}) begin
                n_fail++;
                $display("FAIL repeat_model e%0d: got %b expected %b", e,
                    {pressed, press_pulse, release_pulse, repeat_pulse},
                    {e_pressed, e_press, e_release, e_repeat});
            end
            if (p > 0) begin
                want = (e == p + 10) || (e == p + 13) || (e == p + 16) ||
                       (e == p + 19) || (e == p + 22) || (e == p + 25) ||
                       (e == p + 28) || (e == p + 31);
                n_checks++;
                if (repeat_pulse[1] !== want) begin
                    n_fail++;
                    $display("FAIL repeat_pulse e%0d p%0d: got %b expected %b",
                        e, p, repeat_pulse[1], want);
                end
            end
        end
        n_checks++;
        if (p != 7) begin
            n_fail++;
            $display("FAIL repeat_press_edge: got %0d expected 7", p);
        end
        key_n[1] = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (e >= 3) begin
                n_checks++;
                if (repeat_pulse[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL repeat_after_release e%0d: got %b expected 0",
                        e, repeat_pulse[1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        settle();
        key_n[1] = 1'b0;
        for (int e = 1; e <= 10; e++) tick();
        key_n[0] = 1'b0;
        for (int e = 1; e <= 5; e++) tick();
        n_checks++;
        if (pressed !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got %b expected 0010", pressed);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({pressed, press_pulse, release_pulse, repeat_pulse} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b expected 0",
                {pressed, press_pulse, release_pulse, repeat_pulse});
        end
        tick();
        tick();
        @(negedge clock) reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks++;
            if (press_pulse !== ((e == 7) ? 4'b0011 : 4'b0000)) begin
                n_fail++;
                $display("FAIL reset_mid_press e%0d: got %b", e, press_pulse);
            end
        end
    endtask

    task automatic test_simultaneous();
        settle();
        key_n = 4'b1010;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks++;
            if (press_pulse !== ((e == 7) ? 4'b0101 : 4'b0000) ||
                pressed !== ((e >= 7) ? 4'b0101 : 4'b0000)) begin
                n_fail++;
                $display("FAIL simultaneous e%0d: got p=%b pp=%b", e,
                    pressed, press_pulse);
            end
        end
    endtask

    task automatic test_random();
        int hold[NK];
        settle();
        for (int k = 0; k < NK; k++) hold[k] = 1;
        for (int c = 1; c <= 3000; c++) begin
            for (int k = 0; k < NK; k++) begin
                hold[k]--;
                if (hold[k] <= 0) begin
                    key_n[k] = ~key_n[k];
                    hold[k] = ($urandom_range(0, 3) == 0)
                            ? int'($urandom_range(15, 45))
                            : int'($urandom_range(1, 8));
                end
            end
            if (c == 1500) begin
                #2 reset = 1'b1;
                #1;
                @(negedge clock) reset = 1'b0;
            end
            tick();
            n_checks++;
            if ({pressed, press_pulse, release_pulse, repeat_pulse} !==
                {e_pressed, e_press, e_release, e_repeat}) begin
                n_fail++;
                $display("FAIL random c%0d: got %b expected %b", c,
                    {pressed, press_pulse, release_pulse, repeat_pulse},
                    {e_pressed, e_press, e_release, e_repeat});
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_auto_repeat();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_checks, n_fail);
        $finish;
    end

endmodule
